// File: rtl/crc_word_packer.sv
// Packs a byte stream into DATA_W-bit words for the crc engine and returns word+CRC on a valid/ready port.
// Optional WAIT timeout with m_err reporting is enabled by defining CRC_PACKER_TIMEOUT_EN.
module crc_word_packer #(
    parameter int unsigned DATA_W   = 256,
    parameter int unsigned CRC_W    = 32,
    parameter logic [7:0]  PAD_BYTE = 8'h00,
    parameter int unsigned TIMEOUT  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [7:0]        s_data,
    input  logic              s_last,
    output logic [DATA_W-1:0] data_raw,
    output logic              crc_rst,
    input  logic              crc_done,
    input  logic [CRC_W-1:0]  crc_in,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_word,
    output logic [CRC_W-1:0]  m_crc,
    output logic [5:0]        m_len,
    output logic              m_last,
    output logic              m_err
);

    localparam int unsigned NBYTES = DATA_W / 8;
    localparam int unsigned CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [DATA_W-1:0] PAD_WORD = {NBYTES{PAD_BYTE}};

    // m_len is 6 bits wide, so at most 63 bytes per word can be described.
    if ((DATA_W % 8) != 0 || NBYTES == 0 || NBYTES > 63 || TIMEOUT == 0) begin : g_bad_cfg
        $error("crc_word_packer: unsupported DATA_W/TIMEOUT configuration");
    end

    typedef enum logic [1:0] {
        ST_FILL,
        ST_LOAD,
        ST_WAIT,
        ST_OUT
    } state_t;

    state_t             state;
    logic [DATA_W-1:0]  word;
    logic [CNT_W-1:0]   count;
    logic               accept;

    assign data_raw = word;
    assign m_word   = word;
    assign accept   = s_valid & s_ready;

`ifdef CRC_PACKER_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] to_cnt;
`else
    assign m_err = 1'b0;
`endif

    // Fill -> freeze (LOAD) -> engine runs (WAIT) -> hold result until taken (OUT).
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_FILL;
            s_ready <= 1'b1;
            crc_rst <= 1'b1;
            word    <= PAD_WORD;
            count   <= '0;
            m_valid <= 1'b0;
            m_crc   <= '0;
            m_len   <= '0;
            m_last  <= 1'b0;
`ifdef CRC_PACKER_TIMEOUT_EN
            m_err   <= 1'b0;
            to_cnt  <= '0;
`endif
        end else begin
            case (state)
                ST_FILL: begin
                    if (accept) begin
                        for (int unsigned i = 0; i < NBYTES; i++) begin
                            if (count == CNT_W'(i)) begin
                                word[(NBYTES-1-i)*8 +: 8] <= s_data;
                            end
                        end
                        count <= count + CNT_W'(1);
                        // A full word closes even without s_last; the packet continues in the next word.
                        if (s_last || count == CNT_W'(NBYTES - 1)) begin
                            state   <= ST_LOAD;
                            s_ready <= 1'b0;
                            m_len   <= 6'(count) + 6'd1;
                            m_last  <= s_last;
                        end
                    end
                end
                ST_LOAD: begin
                    state   <= ST_WAIT;
                    crc_rst <= 1'b0;
`ifdef CRC_PACKER_TIMEOUT_EN
                    to_cnt  <= '0;
`endif
                end
                ST_WAIT: begin
                    if (crc_done) begin
                        m_crc   <= crc_in;
                        m_valid <= 1'b1;
                        crc_rst <= 1'b1;
                        state   <= ST_OUT;
                    end
`ifdef CRC_PACKER_TIMEOUT_EN
                    else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
                        m_crc   <= '0;
                        m_err   <= 1'b1;
                        m_valid <= 1'b1;
                        crc_rst <= 1'b1;
                        state   <= ST_OUT;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
`endif
                end
                ST_OUT: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        word    <= PAD_WORD;
                        count   <= '0;
                        s_ready <= 1'b1;
                        state   <= ST_FILL;
`ifdef CRC_PACKER_TIMEOUT_EN
                        m_err   <= 1'b0;
`endif
                    end
                end
                default: begin
                    state <= ST_FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_crc_word_packer.sv
// Self-checking bench for crc_word_packer: byte driver with a word model, a stub crc engine, and a scoreboard monitor.
module tb_crc_word_packer;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic [7:0]   s_data = 8'h00;
    logic         s_last = 1'b0;
    logic [255:0] data_raw;
    logic         crc_rst;
    logic         crc_done = 1'b0;
    logic [31:0]  crc_in = 32'h0;
    logic         m_valid;
    logic         m_ready = 1'b0;
    logic [255:0] m_word;
    logic [31:0]  m_crc;
    logic [5:0]   m_len;
    logic         m_last;
    logic         m_err;

    crc_word_packer dut (
        .clk      (clk),
        .rst      (rst),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .s_last   (s_last),
        .data_raw (data_raw),
        .crc_rst  (crc_rst),
        .crc_done (crc_done),
        .crc_in   (crc_in),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_word   (m_word),
        .m_crc    (m_crc),
        .m_len    (m_len),
        .m_last   (m_last),
        .m_err    (m_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [255:0] word;
        logic [5:0]   len;
        logic         last;
        logic [31:0]  crc;
        logic         err;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         errors = 0;
    int         checks = 0;
    logic [7:0] pkt [0:63];
    int         eng_delay = 1;
    bit         eng_en = 1'b1;
    bit         force_done = 1'b0;
    int         wcnt = 0;

    // Stand-in for the engine's CRC: any fixed mixing of the word works.
    function automatic logic [31:0] fake_crc(input logic [255:0] w);
        return w[31:0] ^ w[255:224] ^ {w[127:112], w[143:128]} ^ 32'h1234_5678;
    endfunction

    // Stub crc engine: raises done eng_delay cycles after crc_rst drops.
    initial forever begin
        @(negedge clk);
        crc_done = 1'b0;
        if (force_done) begin
            crc_done = 1'b1;
            crc_in   = 32'hDEAD_BEEF;
        end else if (eng_en && rst === 1'b0 && crc_rst === 1'b0) begin
            wcnt++;
            crc_in = fake_crc(data_raw);
            if (wcnt >= eng_delay) crc_done = 1'b1;
        end else begin
            wcnt = 0;
        end
    end

    // Scoreboard: every output handshake must match the oldest expected word.
    initial forever begin
        @(negedge clk);
        #1;
        if (rst === 1'b0 && m_valid === 1'b1 && m_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_word: got m_word=%h but no word was expected", m_word);
            end else begin
                mon_e = exp_q.pop_front();
                checks++;
                if (m_word !== mon_e.word) begin
                    errors++; $display("FAIL sb_word: got %h expected %h", m_word, mon_e.word);
                end
                checks++;
                if (m_crc !== mon_e.crc) begin
                    errors++; $display("FAIL sb_crc: got %h expected %h", m_crc, mon_e.crc);
                end
                checks++;
                if (m_len !== mon_e.len) begin
                    errors++; $display("FAIL sb_len: got %0d expected %0d", m_len, mon_e.len);
                end
                checks++;
                if (m_last !== mon_e.last) begin
                    errors++; $display("FAIL sb_last: got %b expected %b", m_last, mon_e.last);
                end
                checks++;
                if (m_err !== mon_e.err) begin
                    errors++; $display("FAIL sb_err: got %b expected %b", m_err, mon_e.err);
                end
            end
        end
    end

    // Drives pkt[0..n-1] and pushes the model's words; returns on the negedge after the last accept.
    task automatic send_pkt(input int n);
        logic [255:0] mw;
        exp_t         e;
        int           pos;
        int           t;
        mw = '0;
        for (int i = 0; i < n; i++) begin
            pos     = i % 32;
            mw      = mw | (256'(pkt[i]) << ((31 - pos) * 8));
            s_valid = 1'b1;
            s_data  = pkt[i];
            s_last  = (i == n - 1);
            t = 0;
            while (s_ready !== 1'b1 && t < 300) begin
                @(negedge clk);
                t++;
            end
            if (t >= 300) begin
                checks++; errors++;
                $display("FAIL send_timeout: s_ready=%b at byte %0d, expected 1", s_ready, i);
                s_valid = 1'b0;
                s_last  = 1'b0;
                return;
            end
            @(negedge clk);
            if (pos == 31 || i == n - 1) begin
                e.word = mw;
                e.len  = 6'(pos + 1);
                e.last = (i == n - 1);
                e.crc  = fake_crc(mw);
                e.err  = 1'b0;
                exp_q.push_back(e);
                mw = '0;
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({s_ready, crc_rst, m_valid, m_len, m_last, m_err} !== {1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_ctrl: got rdy/crst/val/len/last/err=%b/%b/%b/%0d/%b/%b expected 1/1/0/0/0/0",
                     s_ready, crc_rst, m_valid, m_len, m_last, m_err);
        end
        checks++;
        if (data_raw !== 256'h0) begin errors++; $display("FAIL reset_data_raw: got %h expected 0", data_raw); end
        checks++;
        if (m_word !== 256'h0) begin errors++; $display("FAIL reset_m_word: got %h expected 0", m_word); end
        checks++;
        if (m_crc !== 32'h0) begin errors++; $display("FAIL reset_m_crc: got %h expected 0", m_crc); end
    endtask

    task automatic test_full_word;
        logic [255:0] ref_w;
        int t;
        ref_w = 256'h0123456789ABCDEF00112233445566778899AABBCCDDEEFF0F1E2D3C4B5A6978;
        for (int i = 0; i < 32; i++) pkt[i] = 8'(ref_w >> ((31 - i) * 8));
        m_ready   = 1'b1;
        eng_delay = 3;
        send_pkt(32);
        checks++;
        if (crc_rst !== 1'b1 || s_ready !== 1'b0) begin
            errors++; $display("FAIL full_load: got crc_rst=%b s_ready=%b expected 1/0", crc_rst, s_ready);
        end
        @(negedge clk);
        checks++;
        if (crc_rst !== 1'b0) begin errors++; $display("FAIL full_wait_crc_rst: got %b expected 0", crc_rst); end
        checks++;
        if (data_raw !== ref_w) begin errors++; $display("FAIL full_data_raw: got %h expected %h", data_raw, ref_w); end
        t = 0;
        while (exp_q.size() != 0 && t < 500) begin @(negedge clk); t++; end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL full_drain: got %0d pending words expected 0", exp_q.size()); end
    endtask

    task automatic test_short;
        int t;
        pkt[0] = 8'hAA; pkt[1] = 8'hBB; pkt[2] = 8'hCC;
        eng_delay = 1;
        send_pkt(3);
        @(negedge clk);
        checks++;
        if (data_raw !== {24'hAABBCC, 232'h0}) begin
            errors++; $display("FAIL short_data_raw: got %h expected %h", data_raw, {24'hAABBCC, 232'h0});
        end
        t = 0;
        while (exp_q.size() != 0 && t < 500) begin @(negedge clk); t++; end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL short_drain: got %0d pending words expected 0", exp_q.size()); end
    endtask

    task automatic test_multi_word;
        int t;
        for (int i = 0; i < 40; i++) pkt[i] = 8'($urandom_range(1, 255));
        eng_delay = 2;
        send_pkt(40);
        t = 0;
        while (exp_q.size() != 0 && t < 500) begin @(negedge clk); t++; end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL multi_drain: got %0d pending words expected 0", exp_q.size()); end
    endtask

    task automatic test_backpressure;
        exp_t front;
        int   t;
        m_ready = 1'b0;
        pkt[0] = 8'h11; pkt[1] = 8'h22; pkt[2] = 8'h33;
        send_pkt(3);
        t = 0;
        while (m_valid !== 1'b1 && t < 100) begin @(negedge clk); t++; end
        checks++;
        if (m_valid !== 1'b1 || exp_q.size() == 0) begin
            errors++; $display("FAIL bp_valid: got m_valid=%b expected 1", m_valid);
        end else begin
            front = exp_q[0];
            for (int i = 0; i < 10; i++) begin
                force_done = (i == 4);
                @(negedge clk);
                checks++;
                if (m_valid !== 1'b1 || s_ready !== 1'b0) begin
                    errors++; $display("FAIL bp_hold_ctrl: got m_valid=%b s_ready=%b expected 1/0", m_valid, s_ready);
                end
                checks++;
                if (m_word !== front.word) begin errors++; $display("FAIL bp_hold_word: got %h expected %h", m_word, front.word); end
                checks++;
                if (m_crc !== front.crc) begin errors++; $display("FAIL bp_hold_crc: got %h expected %h", m_crc, front.crc); end
            end
        end
        force_done = 1'b0;
        m_ready = 1'b1;
        t = 0;
        while (exp_q.size() != 0 && t < 500) begin @(negedge clk); t++; end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL bp_drain: got %0d pending words expected 0", exp_q.size()); end
    endtask

    task automatic test_rst_in_wait;
        int t;
        eng_en = 1'b0;
        for (int i = 0; i < 5; i++) pkt[i] = 8'(8'hA0 + i);
        send_pkt(5);
        t = 0;
        while (crc_rst !== 1'b0 && t < 50) begin @(negedge clk); t++; end
        checks++;
        if (crc_rst !== 1'b0) begin errors++; $display("FAIL rst_enter_wait: got crc_rst=%b expected 0", crc_rst); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        checks++;
        if ({s_ready, crc_rst, m_valid, m_len, m_last, m_err} !== {1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL rst_wait_ctrl: got rdy/crst/val/len/last/err=%b/%b/%b/%0d/%b/%b expected 1/1/0/0/0/0",
                     s_ready, crc_rst, m_valid, m_len, m_last, m_err);
        end
        checks++;
        if (data_raw !== 256'h0 || m_crc !== 32'h0) begin
            errors++; $display("FAIL rst_wait_data: got data_raw=%h m_crc=%h expected 0/0", data_raw, m_crc);
        end
        eng_en = 1'b1;
        pkt[0] = 8'h5A;
        send_pkt(1);
        @(negedge clk);
        checks++;
        if (data_raw !== {8'h5A, 248'h0}) begin errors++; $display("FAIL rst_new_data_raw: got %h expected %h", data_raw, {8'h5A, 248'h0}); end
        t = 0;
        while (exp_q.size() != 0 && t < 500) begin @(negedge clk); t++; end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL rst_drain: got %0d pending words expected 0", exp_q.size()); end
    endtask

    task automatic test_timeout;
        int t;
        int n;
        eng_en  = 1'b0;
        m_ready = 1'b0;
        pkt[0]  = 8'h77;
        send_pkt(1);
`ifdef CRC_PACKER_TIMEOUT_EN
        n = 0;
        t = 0;
        while (m_valid !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
            if (crc_rst === 1'b0 && m_valid !== 1'b1) n++;
        end
        checks++;
        if (n != 64) begin errors++; $display("FAIL to_wait_cycles: got %0d expected 64", n); end
        checks++;
        if (m_valid !== 1'b1 || m_err !== 1'b1 || m_crc !== 32'h0) begin
            errors++; $display("FAIL to_result: got val/err/crc=%b/%b/%h expected 1/1/0", m_valid, m_err, m_crc);
        end
        if (exp_q.size() != 0) begin
            exp_q[exp_q.size() - 1].crc = 32'h0;
            exp_q[exp_q.size() - 1].err = 1'b1;
        end
        m_ready = 1'b1;
        t = 0;
        while (exp_q.size() != 0 && t < 500) begin @(negedge clk); t++; end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL to_drain: got %0d pending words expected 0", exp_q.size()); end
        @(negedge clk);
        checks++;
        if (m_err !== 1'b0) begin errors++; $display("FAIL to_err_clear: got %b expected 0", m_err); end
`else
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (m_valid !== 1'b0) n++;
        end
        checks++;
        if (n != 0) begin errors++; $display("FAIL no_to_valid: got m_valid high for %0d cycles expected 0", n); end
        checks++;
        if (crc_rst !== 1'b0 || m_err !== 1'b0) begin
            errors++; $display("FAIL no_to_wait: got crc_rst=%b m_err=%b expected 0/0", crc_rst, m_err);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        m_ready = 1'b1;
`endif
        eng_en = 1'b1;
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_short();
        test_multi_word();
        test_backpressure();
        test_rst_in_wait();
        test_timeout();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
